a2d_arbiter: RTL
================

Name: a2d_arbiter

Overview:
- Shares the single A2D converter between two requesters: requester 0 is the motion/PID controller (IR sensor channels) and requester 1 is the battery/housekeeping monitor.
- Sequences each conversion: grant, start pulse, channel address, wait for completion, return the result.
- Guards against a hung converter with a completion timeout.
- Sits between the requesters and the A2D interface block.

Parameters:
- TIMEOUT_CYC, 1024: cycles allowed in WAIT for a2d_cnv_cmplt before the conversion is aborted. Minimum 4.
- RES_W, 12: width of the A2D result.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  conversion request, requester 0 (motion). Level.
- chnl0  in  3  A2D channel address for requester 0.
- req1  in  1  conversion request, requester 1 (battery monitor). Level.
- chnl1  in  3  A2D channel address for requester 1.
- gnt0  out  1  requester 0 owns the converter.
- gnt1  out  1  requester 1 owns the converter.
- vld0  out  1  one-cycle pulse: res_out valid for requester 0.
- vld1  out  1  one-cycle pulse: res_out valid for requester 1.
- err0  out  1  one-cycle pulse: requester 0 conversion timed out.
- err1  out  1  one-cycle pulse: requester 1 conversion timed out.
- res_out  out  RES_W  last completed conversion result (registered).
- busy  out  1  high whenever state is not IDLE.
- a2d_strt_cnv  out  1  start-conversion pulse to A2D.
- a2d_addr  out  3  channel address to A2D.
- a2d_cnv_cmplt  in  1  A2D conversion complete (one-cycle pulse).
- a2d_res  in  RES_W  A2D result, valid while a2d_cnv_cmplt is high.

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - State goes to IDLE.
  - gnt*, vld*, err*, busy, a2d_strt_cnv all 0; a2d_addr=0; res_out=0; timeout counter=0.
  - Reset wins over every other event, including mid-conversion. An in-flight conversion is abandoned and no vld/err is issued for it.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - Samples req0/req1 each edge. If either is high, latch the winner id and its chnl into a2d_addr, then go to START.
  - Arbitration without the macro is fixed priority: req0 beats req1.
  - a2d_cnv_cmplt is ignored in IDLE (stale completions are dropped).
- START (1 cycle):
  - a2d_strt_cnv=1, winner's gnt=1, timeout counter cleared, then go to WAIT.
  - Latency: a request sampled at edge k gives a strt_cnv pulse in cycle k+1.
- WAIT:
  - gnt held, a2d_addr held stable, counter increments by 1 per cycle.
  - On a2d_cnv_cmplt=1: res_out<=a2d_res, flag=ok, go to DONE.
  - Else if counter==TIMEOUT_CYC-1: flag=timeout, go to DONE; res_out unchanged.
  - If cnv_cmplt and timeout occur in the same cycle, the completion wins.
- DONE (1 cycle):
  - gnt stays high. vld_winner=1 if flag=ok, else err_winner=1. Then go to IDLE.
  - The requester must drop req at the edge ending DONE if it wants no further service. IDLE samples on the following edge, so there is a one-cycle gap between grants.
- Handshake rules:
  - Requesters hold req and chnl stable until their vld/err pulse.
  - chnl changes after latch in IDLE are ignored.
  - req dropped mid-conversion does not abort; vld/err is still issued.
- Exclusivity and flags:
  - gnt0 and gnt1 are never high together.
  - vld and err are never high together.
  - busy = (state != IDLE).
- Widths:
  - Timeout counter width is clog2(TIMEOUT_CYC); no wrap in normal operation.
  - res_out is a straight copy, with no arithmetic.

Optional Feature:
- Macro: A2D_RR_ARB_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-served pointer is updated in DONE on vld or err.
  - When both req are high in IDLE, grant goes to the requester not served last.
  - Pointer resets to 1, so req0 wins the first contention.
  - A single requester is always granted regardless of pointer.
- Undefined: fixed priority, req0 over req1. No pointer register exists.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req0=1 → all outputs 0, busy=0. The first strt_cnv appears 2 cycles after rst drops (IDLE sample edge, then START).
- Single conversion: req0=1, chnl0=3'b010; A2D returns cnv_cmplt with a2d_res=12'hABC 10 cycles after strt_cnv → a2d_addr=3'b010 from START through WAIT, gnt0 high 12 cycles, vld0 pulse one cycle after cnv_cmplt, res_out=12'hABC, gnt1/vld1 never set.
- Contention: req0 and req1 held high continuously → without macro, every grant goes to requester 0 (req1 starved). With A2D_RR_ARB_EN, grants alternate 0,1,0,1 with one IDLE cycle between them.
- Timeout: TIMEOUT_CYC=16, req1=1, cnv_cmplt never asserted → err1 pulse after exactly 16 WAIT cycles, vld1=0, res_out keeps its previous value (12'hABC), return to IDLE.
- Tie: TIMEOUT_CYC=16, cnv_cmplt=1 with a2d_res=12'h123 on the 16th WAIT cycle → vld pulse, no err, res_out=12'h123.
- Reset mid-operation: rst=1 for one cycle during WAIT, then a late cnv_cmplt with a2d_res=12'hFFF while in IDLE → no vld/err, res_out=0, busy=0, next req serviced normally.

Source files
------------

// File: rtl/a2d_arbiter.sv
// Two-requester arbiter and conversion sequencer for the shared A2D converter.
// Define A2D_RR_ARB_EN for round-robin arbitration; default is fixed priority (req0 first).
module a2d_arbiter #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int RES_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [2:0]       chnl0,
    input  logic             req1,
    input  logic [2:0]       chnl1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             vld0,
    output logic             vld1,
    output logic             err0,
    output logic             err1,
    output logic [RES_W-1:0] res_out,
    output logic             busy,
    output logic             a2d_strt_cnv,
    output logic [2:0]       a2d_addr,
    input  logic             a2d_cnv_cmplt,
    input  logic [RES_W-1:0] a2d_res
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t             state_reg, state_next;
    logic               winner_reg, winner_next;
    logic [2:0]         addr_reg, addr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ok_reg, ok_next;
    logic [RES_W-1:0]   res_reg, res_next;
    logic               pick;

`ifdef A2D_RR_ARB_EN
    // last_reg remembers who was served last; contention goes to the other one
    logic last_reg, last_next;

    always_comb begin
        if (req0 && req1) begin
            pick = ~last_reg;
        end else begin
            pick = ~req0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end

    always_comb begin
        last_next = last_reg;
        if (state_reg == DONE) begin
            last_next = winner_reg;
        end
    end
`else
    assign pick = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            winner_reg <= 1'b0;
            addr_reg   <= 3'd0;
            cnt_reg    <= '0;
            ok_reg     <= 1'b0;
            res_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            winner_reg <= winner_next;
            addr_reg   <= addr_next;
            cnt_reg    <= cnt_next;
            ok_reg     <= ok_next;
            res_reg    <= res_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        addr_next   = addr_reg;
        cnt_next    = cnt_reg;
        ok_next     = ok_reg;
        res_next    = res_reg;
        case (state_reg)
            IDLE: begin
                // completions arriving here are stale and deliberately ignored
                if (req0 || req1) begin
                    winner_next = pick;
                    addr_next   = pick ? chnl1 : chnl0;
                    state_next  = START;
                end
            end
            START: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // completion takes precedence over a simultaneous timeout
                if (a2d_cnv_cmplt) begin
                    res_next   = a2d_res;
                    ok_next    = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    ok_next    = 1'b0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy         = (state_reg != IDLE);
    assign gnt0         = busy && !winner_reg;
    assign gnt1         = busy && winner_reg;
    assign a2d_strt_cnv = (state_reg == START);
    assign a2d_addr     = addr_reg;
    assign res_out      = res_reg;
    assign vld0         = (state_reg == DONE) && ok_reg && !winner_reg;
    assign vld1         = (state_reg == DONE) && ok_reg && winner_reg;
    assign err0         = (state_reg == DONE) && !ok_reg && !winner_reg;
    assign err1         = (state_reg == DONE) && !ok_reg && winner_reg;

endmodule
